// File: rtl/myproject_mul_pipe_mac.sv
// rtl/myproject_mul_pipe_mac.sv - pipelined signed/unsigned multiplier with optional burst accumulate
// Optional build macro: MYPROJECT_MUL_SAT_EN (saturating output truncation instead of wrap).
module myproject_mul_pipe_mac #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 12,
    parameter int din1_WIDTH  = 9,
    parameter bit DIN0_SIGNED = 1'b1,
    parameter bit DIN1_SIGNED = 1'b0,
    parameter bit ACC_EN      = 1'b1,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT       = 0,
    parameter int dout_WIDTH  = 21
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  acc_first,
    input  logic                  acc_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout
);
    localparam int PW          = din0_WIDTH + din1_WIDTH;
    localparam bit PROD_SIGNED = DIN0_SIGNED || DIN1_SIGNED;
    localparam int PDEPTH      = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    logic                  v_q [NUM_STAGE];
    logic                  f_q [NUM_STAGE];
    logic                  l_q [NUM_STAGE];
    logic signed [PW-1:0]  p_q [PDEPTH];
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic signed [PW-1:0]  prod_c;
    logic signed [PW-1:0]  prod_last;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc_q;

    // Extending both operands to PW before a PW-wide multiply keeps the low PW bits exact for any signedness mix.
    assign a_ext     = {{din1_WIDTH{DIN0_SIGNED & a_q[din0_WIDTH-1]}}, a_q};
    assign b_ext     = {{din0_WIDTH{DIN1_SIGNED & b_q[din1_WIDTH-1]}}, b_q};
    assign prod_c    = a_ext * b_ext;
    assign prod_last = (NUM_STAGE == 1) ? prod_c : p_q[PDEPTH-1];

    always_comb begin
        if (PROD_SIGNED) begin
            prod_ext = ACC_WIDTH'(prod_last);
        end else begin
            prod_ext = ACC_WIDTH'($unsigned(prod_last));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                v_q[k] <= 1'b0;
                f_q[k] <= 1'b0;
                l_q[k] <= 1'b0;
            end
            for (int k = 0; k < PDEPTH; k++) begin
                p_q[k] <= '0;
            end
            acc_q     <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            a_q    <= din0;
            b_q    <= din1;
            v_q[0] <= in_valid;
            f_q[0] <= acc_first;
            l_q[0] <= acc_last;
            for (int k = 1; k < NUM_STAGE; k++) begin
                v_q[k] <= v_q[k-1];
                f_q[k] <= f_q[k-1];
                l_q[k] <= l_q[k-1];
            end
            p_q[0] <= prod_c;
            for (int k = 1; k < PDEPTH; k++) begin
                p_q[k] <= p_q[k-1];
            end
            out_valid <= v_q[NUM_STAGE-1] && (!ACC_EN || l_q[NUM_STAGE-1]);
            // Bubbles leave acc untouched; a continuation with no open burst adds onto whatever acc holds.
            if (v_q[NUM_STAGE-1]) begin
                if (!ACC_EN || f_q[NUM_STAGE-1]) begin
                    acc_q <= prod_ext;
                end else begin
                    acc_q <= acc_q + prod_ext;
                end
            end
        end
    end

`ifdef MYPROJECT_MUL_SAT_EN
    localparam logic [dout_WIDTH-1:0] SMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] SMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] shifted;

    always_comb begin
        if (PROD_SIGNED) begin
            shifted = $signed(acc_q) >>> SHIFT;
        end else begin
            shifted = acc_q >> SHIFT;
        end
        dout = shifted[dout_WIDTH-1:0];
        if (PROD_SIGNED) begin
            // Representable only when every bit above the result sign bit matches it.
            if ((|shifted[ACC_WIDTH-1:dout_WIDTH-1]) && !(&shifted[ACC_WIDTH-1:dout_WIDTH-1])) begin
                dout = shifted[ACC_WIDTH-1] ? SMIN : SMAX;
            end
        end else if (|shifted[ACC_WIDTH-1:dout_WIDTH]) begin
            dout = '1;
        end
    end
`else
    always_comb begin
        if (PROD_SIGNED) begin
            dout = dout_WIDTH'($signed(acc_q) >>> SHIFT);
        end else begin
            dout = dout_WIDTH'(acc_q >> SHIFT);
        end
    end
`endif

endmodule

// File: doc/myproject_mul_pipe_mac.md
Name: myproject_mul_pipe_mac

Overview:
- Parametrised, pipelined successor to the single-cycle combinational multiplier used in the dense layers.
- Multiplies two operands with per-operand signedness selection, then optionally accumulates products over a tagged burst (MAC).
- Drives a width-reduced result with valid tracking and clock-enable stall.
- Sits between the weight/activation streams and the bias-add stage of the generated kernels.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, multiply pipeline depth; legal range 1..4.
- din0_WIDTH, 12, operand A width.
- din1_WIDTH, 9, operand B width.
- DIN0_SIGNED, 1, 1 = A is two's complement; 0 = A is unsigned.
- DIN1_SIGNED, 0, 1 = B is two's complement; 0 = B is unsigned (zero-extended).
- ACC_EN, 1, 1 = accumulate mode; 0 = plain pipelined multiply.
- ACC_WIDTH, 32, accumulator width; must be >= din0_WIDTH+din1_WIDTH.
- SHIFT, 0, right shift (arithmetic) applied to the accumulator before output truncation.
- dout_WIDTH, 21, result width.

Ports:
- ap_clk  in  1  clock; all registers rising-edge.
- ap_rst  in  1  synchronous active-high reset.
- ce  in  1  clock enable; 0 freezes every register, including valid and tags.
- in_valid  in  1  operands and tags valid this cycle (sampled only when ce=1).
- acc_first  in  1  this item starts a new accumulation burst.
- acc_last  in  1  this item ends the burst; the result is emitted after it.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- out_valid  out  1  dout is valid this cycle.
- dout  out  dout_WIDTH  result.

Behaviour:
- Product width PW = din0_WIDTH+din1_WIDTH.
  - Each operand is extended to PW per its SIGNED parameter.
  - The product is exact for every signedness combination.
- Pipeline:
  - Stage 1 registers the operands, in_valid, acc_first and acc_last.
  - Stages 2..NUM_STAGE carry the product, valid and tags.
  - The accumulator/output register adds one more cycle.
  - Latency from accepted input to out_valid is exactly NUM_STAGE+1 cycles.
- Throughput: one item per cycle while ce=1; no backpressure beyond ce.
- ce=0: all pipeline state holds, and out_valid/dout hold their last values.
  - The bench must count a held out_valid=1 as one result per ce=1 cycle only.
- Accumulate, ACC_EN=1, applied when a valid item reaches the last stage:
  - acc_first=1: acc = sext(product).
  - acc_first=0: acc = acc + sext(product), wrapping at ACC_WIDTH.
  - acc_first and acc_last both 1: single-item burst; acc = product and the result is emitted.
  - out_valid=1 for one cycle after an item with acc_last=1; otherwise out_valid=0.
  - An acc_first=0 item with no prior burst open accumulates onto the current acc value (0 after reset).
- ACC_EN=0: tags are ignored; every valid item produces out_valid=1 with acc = product.
- Output: dout = (acc >>> SHIFT) truncated to its low dout_WIDTH bits. Truncation wraps unless the optional feature is compiled in.
  - The shift is arithmetic if either operand is signed, logical otherwise.
- Reset, ap_rst=1 at a rising edge with ce ignored:
  - All valid bits, tags and acc clear to 0; out_valid=0; dout=0.
  - Items in flight are discarded with no partial output.
  - The first accepted input after reset release is in the pipeline on the next edge.
- in_valid=0 cycles create bubbles; acc is unchanged by bubbles.

Optional Feature:
- Macro: MYPROJECT_MUL_SAT_EN.
- Defined: output truncation saturates.
  - Signed result: values above 2^(dout_WIDTH-1)-1 clamp to that maximum; values below -2^(dout_WIDTH-1) clamp to that minimum.
  - Unsigned result: clamps to 2^dout_WIDTH-1.
  - acc itself still wraps at ACC_WIDTH.
- Undefined: plain bit truncation (wrap); no saturation logic is synthesised.

Test Plan:
- Defaults, ACC_EN=0: din0=-2048 (0x800), din1=511 -> dout=-1046528 exactly 3 cycles later, out_valid pulse of 1 cycle.
- ACC_EN=1, burst of (100,10,first), (200,20), (-50,4,last) on consecutive cycles -> single out_valid with dout=4800; no out_valid for the first two items.
- Back-to-back bursts (7,3,first+last) then (5,5,first+last) -> out_valid on two consecutive cycles, dout=21 then 25; the second burst is unaffected by the first.
- ce=0 for 3 cycles mid-burst with the same 3-item burst -> dout=4800, delayed by exactly 3 cycles; pipeline contents preserved.
- Overflow: three items (2047,511), last on the third -> without MYPROJECT_MUL_SAT_EN dout=1040899 (wrap of 3138051); with the macro dout=1048575.
- ap_rst asserted for 1 cycle while 2 items are in flight -> out_valid stays 0, dout=0; the next burst (1,1,first+last) yields dout=1 with no residue from before reset.
